// File: rtl/alu_arb_pkg.sv
// Shared opcodes, FSM encoding and defaults for the ALU request arbiter.
// Optional ALU_ARB_TIMEOUT_EN macro enables the WAIT-state watchdog.
package alu_arb_pkg;

    localparam logic [1:0] OP_XOR = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_OR  = 2'b10;
    localparam logic [1:0] OP_ADD = 2'b11;

    localparam int DEF_TIMEOUT = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/alu_req_arbiter_rr_grant.sv
// Combinational round-robin picker: first request at or after ptr,
// searching upward with wrap; returns one-hot grant and encoded id.
module rr_grant #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  id
);

    logic found;
    int   slot;

    always_comb begin
        gnt   = '0;
        id    = '0;
        found = 1'b0;
        slot  = 0;
        for (int i = 0; i < N_REQ; i++) begin
            slot = int'(ptr) + i;
            if (slot >= N_REQ) begin
                slot = slot - N_REQ;
            end
            for (int k = 0; k < N_REQ; k++) begin
                if (!found && (k == slot) && req[k]) begin
                    found  = 1'b1;
                    gnt[k] = 1'b1;
                    id     = ID_W'(k);
                end
            end
        end
    end

endmodule

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one ALU between N_REQ requesters.
// Define ALU_ARB_TIMEOUT_EN to abort WAIT after TIMEOUT cycles (o_timeout).
module alu_req_arbiter
    import alu_arb_pkg::*;
#(
    parameter int N_BITS  = 32,
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                    i_clock,
    input  logic                    i_reset_n,
    input  logic [N_REQ-1:0]        i_req_valid,
    input  logic [N_REQ*N_BITS-1:0] i_req_data_a,
    input  logic [N_REQ*N_BITS-1:0] i_req_data_b,
    input  logic [N_REQ*2-1:0]      i_req_operation,
    output logic [N_REQ-1:0]        o_req_ready,
    output logic [N_BITS-1:0]       o_alu_data_a,
    output logic [N_BITS-1:0]       o_alu_data_b,
    output logic [1:0]              o_alu_operation,
    output logic                    o_alu_valid,
    input  logic [N_BITS-1:0]       i_alu_data,
    input  logic                    i_alu_valid,
    output logic                    o_rsp_valid,
    output logic [N_BITS-1:0]       o_rsp_data,
    output logic [ID_W-1:0]         o_rsp_id,
    input  logic                    i_rsp_ready,
`ifdef ALU_ARB_TIMEOUT_EN
    output logic                    o_timeout,
`endif
    output logic                    o_busy
);

    state_e            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [N_BITS-1:0] a_q, a_d;
    logic [N_BITS-1:0] b_q, b_d;
    logic [1:0]        op_q, op_d;
    logic [N_BITS-1:0] rsp_q, rsp_d;
    logic              alu_valid_q, alu_valid_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              busy_q, busy_d;

    logic [N_REQ-1:0]  gnt;
    logic [ID_W-1:0]   gnt_id;
    logic [N_BITS-1:0] sel_a;
    logic [N_BITS-1:0] sel_b;
    logic [1:0]        sel_op;
    logic [ID_W-1:0]   ptr_next;

`ifdef ALU_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
`endif

    rr_grant #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_grant (
        .req (i_req_valid),
        .ptr (ptr_q),
        .gnt (gnt),
        .id  (gnt_id)
    );

    // Ready is forced low while reset is held so every output reads 0.
    assign o_req_ready = (state_q == ST_IDLE && i_reset_n) ? gnt : '0;

    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (gnt[k]) begin
                sel_a  = i_req_data_a[k*N_BITS +: N_BITS];
                sel_b  = i_req_data_b[k*N_BITS +: N_BITS];
                sel_op = i_req_operation[2*k +: 2];
            end
        end
    end

    assign ptr_next = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        rsp_d       = rsp_q;
        alu_valid_d = 1'b0;
        rsp_valid_d = rsp_valid_q;
        busy_d      = busy_q;
`ifdef ALU_ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
        timeout_d   = timeout_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (|(i_req_valid & o_req_ready)) begin
                    a_d         = sel_a;
                    b_d         = sel_b;
                    op_d        = sel_op;
                    id_d        = gnt_id;
                    alu_valid_d = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
`ifdef ALU_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_alu_valid) begin
                    rsp_d       = i_alu_data;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end
`ifdef ALU_ARB_TIMEOUT_EN
                // A real result arriving on the last cycle beats the abort.
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rsp_d       = '0;
                    rsp_valid_d = 1'b1;
                    timeout_d   = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ST_RESP: begin
                if (i_rsp_ready) begin
                    ptr_d       = ptr_next;
                    rsp_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            rsp_q       <= '0;
            alu_valid_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            rsp_q       <= rsp_d;
            alu_valid_q <= alu_valid_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

`ifdef ALU_ARB_TIMEOUT_EN
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_timeout = timeout_q;
`endif

    assign o_alu_data_a    = a_q;
    assign o_alu_data_b    = b_q;
    assign o_alu_operation = op_q;
    assign o_alu_valid     = alu_valid_q;
    assign o_rsp_valid     = rsp_valid_q;
    assign o_rsp_data      = rsp_q;
    assign o_rsp_id        = id_q;
    assign o_busy          = busy_q;

endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
Round-robin arbiter that shares one ALU datapath between N_REQ requesters. It accepts one operation per requester through a valid/ready handshake and drives the operands and opcode to the ALU. It waits for the ALU's valid result and returns that result tagged with the requester id. It sits between the requester blocks and the ALU, in the ALU's selected clock domain.

Parameters:
N_BITS, 32, operand/result width; matches the ALU.
N_REQ, 4, number of requesters; legal range 2..8.
ID_W, 2, requester-id width; equals clog2(N_REQ).
TIMEOUT, 15, cycles to wait for i_alu_valid before aborting; used only with the optional feature.

Ports:
i_clock  in  1  clock; the ALU's selected clock.
i_reset_n  in  1  reset, asynchronous, active-low.
i_req_valid  in  N_REQ  per-requester request valid.
i_req_data_a  in  N_REQ*N_BITS  packed operand A; requester k occupies bits [k*N_BITS +: N_BITS].
i_req_data_b  in  N_REQ*N_BITS  packed operand B; same packing as A.
i_req_operation  in  N_REQ*2  packed opcode; requester k occupies bits [2k +: 2].
o_req_ready  out  N_REQ  one-hot grant/accept.
o_alu_data_a  out  N_BITS  operand A to the ALU.
o_alu_data_b  out  N_BITS  operand B to the ALU.
o_alu_operation  out  2  opcode to the ALU.
o_alu_valid  out  1  single-cycle issue strobe.
i_alu_data  in  N_BITS  ALU result.
i_alu_valid  in  1  ALU result valid.
o_rsp_valid  out  1  response valid.
o_rsp_data  out  N_BITS  response result.
o_rsp_id  out  ID_W  index of the requester that owns the response.
i_rsp_ready  in  1  response consumer ready.
o_busy  out  1  high in every state except IDLE.

Behaviour:
- Reset, asynchronous, on i_reset_n=0; takes effect immediately, mid-transaction included:
  - state=IDLE, rr_ptr=0.
  - All outputs 0. Any in-flight operation is dropped and no response is produced.
- State machine: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - If any i_req_valid is set, grant the first requester at or after rr_ptr, searching cyclically upward with wrap from N_REQ-1 to 0.
  - o_req_ready[g] is combinational and is high only in IDLE for the granted g.
  - Handshake completes when valid & ready. The block then latches A, B, operation and g, and moves to ISSUE.
  - Exactly one requester is accepted per transaction.
- ISSUE (1 cycle):
  - o_alu_valid=1 and o_alu_* carry the latched values.
  - o_alu_* keep the latched values through WAIT.
  - Next state is WAIT.
- WAIT: on i_alu_valid=1, capture i_alu_data into the response register and move to RESP. An i_alu_valid seen in IDLE or ISSUE is ignored.
- RESP:
  - o_rsp_valid=1, with o_rsp_data and o_rsp_id stable.
  - On i_rsp_ready=1, set rr_ptr=(g+1) mod N_REQ and return to IDLE.
  - If i_rsp_ready stays low, hold the response indefinitely; no new grant is made.
- Throughput: at most one operation per 4 cycles; minimum latency from accept to o_rsp_valid is 3 cycles.
- Fairness: a continuously requesting requester is granted within N_REQ transactions.
- Simultaneous requests: resolved by rr_ptr only. A requester that drops valid before being granted loses nothing.
- Requester contract: a requester must hold its data while valid is high and not yet granted.
- Arithmetic is performed by the ALU only; this block does not widen or modify any data.

Optional Feature:
Macro ALU_ARB_TIMEOUT_EN.
- With it:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT without i_alu_valid, go to RESP with o_rsp_data=0 and a sticky o_timeout=1 output port.
  - o_timeout clears only on reset.
  - If i_alu_valid arrives in the same cycle as the timeout, the valid result wins.
- Without it: WAIT lasts indefinitely; the counter and the o_timeout port do not exist.

Decomposition:
- Package alu_arb_pkg:
  - opcode constants OP_XOR=2'b00, OP_AND=2'b01, OP_OR=2'b10, OP_ADD=2'b11;
  - state encoding ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP;
  - default TIMEOUT.
- One sub-module, rr_grant: combinational round-robin priority picker with inputs req[N_REQ] and ptr[ID_W], and outputs a one-hot grant plus an encoded id.

Test Plan:
- Single request: requester 2 sends A=5, B=3, op=11. The ALU model returns 8 after 2 cycles. Required: o_rsp_valid with data 8, id 2; o_alu_valid is exactly one pulse.
- All four requesters valid continuously from reset. Required: grant order 0,1,2,3,0; each op returns the correct XOR/AND/OR/ADD result.
- Hold response with i_rsp_ready=0 for 10 cycles. Required: o_rsp_* stable and all o_req_ready=0 throughout; release gives exactly one response.
- Wrap-around: rr_ptr=3 with requesters 0 and 3 valid. Required: grant 3, then 0.
- Reset asserted in WAIT. Required: all outputs 0 immediately, no response; after release, a new request to requester 0 is granted.
- With ALU_ARB_TIMEOUT_EN and TIMEOUT=15: i_alu_valid is never asserted. Required: RESP entered 15 cycles after WAIT entry with data 0 and o_timeout=1.
